// File: rtl/board_io_debounce.sv
// Board-input front end: per-channel synchroniser, polarity fix, counter
// debounce with edge pulses, sticky rise events and a maskable interrupt.
// Sits between the FPGA switch/button pins and the processor's gp_i.

// ---------------------------------------------------------------------------
// One input channel. Everything here is private to the channel; the top only
// combines the event bits into the interrupt.
// ---------------------------------------------------------------------------
module board_io_debounce_lane #(
  parameter int   SyncStages     = 2,
  parameter int   DebounceCycles = 50000,
  parameter logic Invert         = 1'b0
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  input  logic raw_i,
  input  logic clr_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic event_o
);

  localparam int             CntW   = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  event_q, event_d;
  logic                  s;

  // Synchroniser shift: new sample enters at bit 0, oldest stage is the output.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], raw_i};
  end

  // Sync stages reset to the inversion bit so the conditioned value is 0 and
  // no edge is seen when reset is released.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) sync_q <= {SyncStages{Invert}};
    else           sync_q <= sync_d;
  end

  assign s = sync_q[SyncStages-1] ^ Invert;

  // Debounce: count consecutive disagreeing cycles; any agreement restarts
  // the count, so a glitch earns no credit toward the next change.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      level_d = s;
      cnt_d   = '0;
      rise_d  = s;
      fall_d  = ~s;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Sticky event: a rise wins over a simultaneous clear.
  always_comb begin
    event_d = event_q;
    if (rise_q)     event_d = 1'b1;
    else if (clr_i) event_d = 1'b0;
  end

  // Debounce and event state registers.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      event_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      event_q <= event_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign event_o = event_q;

endmodule

// ---------------------------------------------------------------------------
// Top: an array of independent channels plus the registered interrupt.
// ---------------------------------------------------------------------------
module board_io_debounce #(
  parameter int               NumIn          = 8,
  parameter int               SyncStages     = 2,
  parameter int               DebounceCycles = 50000,
  parameter logic [NumIn-1:0] InvertMask     = '0
) (
  input  logic             clk_sys_i,
  input  logic             rst_sys_i,
  input  logic [NumIn-1:0] raw_i,
  input  logic [NumIn-1:0] clr_i,
  input  logic [NumIn-1:0] irq_en_i,
  output logic [NumIn-1:0] level_o,
  output logic [NumIn-1:0] rise_o,
  output logic [NumIn-1:0] fall_o,
  output logic [NumIn-1:0] event_o,
  output logic             irq_o
);

  logic irq_q, irq_d;

  for (genvar g = 0; g < NumIn; g++) begin : g_lane
    board_io_debounce_lane #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles),
      .Invert         (InvertMask[g])
    ) u_lane (
      .clk_sys_i (clk_sys_i),
      .rst_sys_i (rst_sys_i),
      .raw_i     (raw_i[g]),
      .clr_i     (clr_i[g]),
      .level_o   (level_o[g]),
      .rise_o    (rise_o[g]),
      .fall_o    (fall_o[g]),
      .event_o   (event_o[g])
    );
  end

  // Interrupt request from the current registered events and enables.
  always_comb begin
    irq_d = |(event_o & irq_en_i);
  end

  // Interrupt register; lags event/enable changes by one cycle.
  always_ff @(posedge clk_sys_i or posedge rst_sys_i) begin
    if (rst_sys_i) irq_q <= 1'b0;
    else           irq_q <= irq_d;
  end

  assign irq_o = irq_q;

endmodule

// File: tb/tb_board_io_debounce.sv
// Directed bench for board_io_debounce: 4 channels, 2 sync stages,
// 4-cycle debounce, channel 3 active-low.
module tb_board_io_debounce;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw, clr, irq_en;
  logic [3:0] level, rise, fall, evt;
  logic       irq;
  int         n_cmp = 0;
  int         n_err = 0;

  board_io_debounce #(
    .NumIn          (4),
    .SyncStages     (2),
    .DebounceCycles (4),
    .InvertMask     (4'b1000)
  ) dut (
    .clk_sys_i (clk),
    .rst_sys_i (rst),
    .raw_i     (raw),
    .clr_i     (clr),
    .irq_en_i  (irq_en),
    .level_o   (level),
    .rise_o    (rise),
    .fall_o    (fall),
    .event_o   (evt),
    .irq_o     (irq)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] l, input logic [3:0] r,
                         input logic [3:0] f, input logic [3:0] e, input logic i);
    chk({tag, ".level"}, level, l);
    chk({tag, ".rise"},  rise,  r);
    chk({tag, ".fall"},  fall,  f);
    chk({tag, ".event"}, evt,   e);
    chk({tag, ".irq"},   {3'b000, irq}, {3'b000, i});
  endtask

  initial begin
    rst    = 1'b1;
    raw    = 4'b1000;
    clr    = 4'b0000;
    irq_en = 4'b0000;
    tick(); tick();
    chk_all("in_reset", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);

    // 1: release reset with the active-low button idle; nothing may happen.
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk_all($sformatf("idle%0d", i), 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    end

    // 2: ch0 step; level/rise at +6, event +7, irq +8.
    irq_en = 4'b0001;
    raw    = 4'b1001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_all($sformatf("step0_%0d", i),
              (i >= 6) ? 4'b0001 : 4'b0000,
              (i == 6) ? 4'b0001 : 4'b0000,
              4'b0000,
              (i >= 7) ? 4'b0001 : 4'b0000,
              i >= 8);
    end

    // 3a: 3-cycle glitch on ch1 must be discarded.
    raw = 4'b1011;
    tick(); tick(); tick();
    raw = 4'b1001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("glitch_%0d", i), 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b1);
    end

    // 3b: 4-cycle pulse on ch1 is the minimum accepted width.
    raw = 4'b1011;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk_all($sformatf("pulse4_%0d", i),
              (i >= 6 && i <= 9) ? 4'b0011 : 4'b0001,
              (i == 6)  ? 4'b0010 : 4'b0000,
              (i == 10) ? 4'b0010 : 4'b0000,
              (i >= 7)  ? 4'b0011 : 4'b0001,
              1'b1);
      if (i == 4) raw = 4'b1001;
    end

    // 4: active-low button on ch3: press then release.
    raw = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("press_%0d", i),
              (i >= 6) ? 4'b1001 : 4'b0001,
              (i == 6) ? 4'b1000 : 4'b0000,
              4'b0000,
              (i >= 7) ? 4'b1011 : 4'b0011,
              1'b1);
    end
    raw = 4'b1001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("release_%0d", i),
              (i >= 6) ? 4'b0001 : 4'b1001,
              4'b0000,
              (i == 6) ? 4'b1000 : 4'b0000,
              4'b1011,
              1'b1);
    end

    // 5a: plain clear of ch0 event, irq follows a cycle later.
    clr = 4'b0001;
    tick();
    clr = 4'b0000;
    chk_all("clr0", 4'b0001, 4'b0000, 4'b0000, 4'b1010, 1'b1);
    tick();
    chk_all("clr0_irq", 4'b0001, 4'b0000, 4'b0000, 4'b1010, 1'b0);

    // 5b: drop ch0, then re-raise it with clear colliding with the rise.
    raw = 4'b1000;
    for (int i = 1; i <= 8; i++) tick();
    chk_all("ch0_low", 4'b0000, 4'b0000, 4'b0000, 4'b1010, 1'b0);
    raw = 4'b1001;
    for (int i = 1; i <= 9; i++) begin
      tick();
      chk_all($sformatf("setwins_%0d", i),
              (i >= 6) ? 4'b0001 : 4'b0000,
              (i == 6) ? 4'b0001 : 4'b0000,
              4'b0000,
              (i == 7) ? 4'b1011 : 4'b1010,
              i == 8);
      if (i == 6) clr = 4'b0001;
      if (i == 8) clr = 4'b0000;
    end

    // 6: reset mid-debounce on ch2 (counter at 3), then full restart.
    raw = 4'b1101;
    for (int i = 1; i <= 5; i++) tick();
    chk_all("pre_rst", 4'b0001, 4'b0000, 4'b0000, 4'b1010, 1'b0);
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk_all($sformatf("restart_%0d", i),
              (i >= 6) ? 4'b0101 : 4'b0000,
              (i == 6) ? 4'b0101 : 4'b0000,
              4'b0000,
              (i >= 7) ? 4'b0101 : 4'b0000,
              i >= 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
